regression_sample_loader: RTL and testbench

- Host-side initiator for the linear-regression engine's Start/Ready handshake.
- Accepts an (x, y) sample stream over a valid/ready interface and writes the samples into the engine's sample memory at addresses 0..N_SAMPLES-1.
- Pulses eng_start, then waits for the engine to drop and re-raise eng_ready.
- Captures b0, b1 and err, and presents them on a result valid/ready port.
- Sits between the system front end and the regression controller/datapath.

---
 rtl/regression_pkg.sv | 21 ++
 rtl/regression_sample_loader_counter.sv | 35 +++
 rtl/regression_sample_loader.sv | 165 ++++++++++++++++
 tb/tb_regression_sample_loader.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regression_pkg.sv
// Shared definitions for the regression sample loader: FSM state encoding,
// default widths and a helper that sizes the watchdog counter.
package regression_pkg;

  localparam int DEF_DATA_W = 20;
  localparam int DEF_ADDR_W = 8;

  typedef enum logic [2:0] {
    FILL      = 3'd0,
    KICK      = 3'd1,
    WAIT_ACK  = 3'd2,
    WAIT_DONE = 3'd3,
    HOLD      = 3'd4
  } loader_state_e;

  // Enough bits to count 0..timeout-1, never narrower than one bit.
  function automatic int wdogWidth(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/regression_sample_loader_counter.sv
// Up-counter with synchronous active-low clear, count enable and a
// terminal-count flag; an enabled count at terminal value wraps to zero.
module loader_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr_n_i,
  input  logic         en_i,
  input  logic [W-1:0] term_i,
  output logic [W-1:0] count_o,
  output logic         tc_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign tc_o    = (count_q == term_i);
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = tc_o ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/regression_sample_loader.sv
// Host-side initiator for the regression engine: fills the sample memory,
// kicks the engine over Start/Ready, and holds the captured result for a consumer.
module regression_sample_loader
  import regression_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int N_SAMPLES = 150,
  parameter int TIMEOUT   = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_x,
  input  logic [DATA_W-1:0] in_y,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_x,
  output logic [DATA_W-1:0] mem_y,
  output logic              eng_start,
  input  logic              eng_ready,
  input  logic [DATA_W-1:0] eng_b0,
  input  logic [DATA_W-1:0] eng_b1,
  input  logic [DATA_W-1:0] eng_err,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_b0,
  output logic [DATA_W-1:0] res_b1,
  output logic [DATA_W-1:0] res_err,
  output logic              timeout,
  output logic              busy
);

  localparam int                WDOG_W    = wdogWidth(TIMEOUT);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_SAMPLES - 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

  loader_state_e     state_q, state_d;
  logic              ack_seen_q, ack_seen_d;
  logic [DATA_W-1:0] b0_q, b0_d;
  logic [DATA_W-1:0] b1_q, b1_d;
  logic [DATA_W-1:0] err_q, err_d;
  logic              timeout_q, timeout_d;

  logic              beat;
  logic              in_done_wait;
  logic [ADDR_W-1:0] wr_cnt;
  logic              wr_last;
  logic [WDOG_W-1:0] wdog_count_unused;
  logic              wdog_last;

  assign beat         = (state_q == FILL) && in_valid;
  assign in_done_wait = (state_q == WAIT_DONE);

  loader_counter #(.W(ADDR_W)) u_wr_cnt (
    .clk     (clk),
    .clr_n_i (rst),
    .en_i    (beat),
    .term_i  (LAST_ADDR),
    .count_o (wr_cnt),
    .tc_o    (wr_last)
  );

  // Watchdog is held at zero outside WAIT_DONE so every wait starts fresh.
  loader_counter #(.W(WDOG_W)) u_wdog (
    .clk     (clk),
    .clr_n_i (rst && in_done_wait),
    .en_i    (in_done_wait),
    .term_i  (WDOG_LAST),
    .count_o (wdog_count_unused),
    .tc_o    (wdog_last)
  );

  always_comb begin
    state_d    = state_q;
    ack_seen_d = 1'b0;
    b0_d       = b0_q;
    b1_d       = b1_q;
    err_d      = err_q;
    timeout_d  = timeout_q;
    in_ready   = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_x      = '0;
    mem_y      = '0;
    eng_start  = 1'b0;
    res_valid  = 1'b0;
    case (state_q)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mem_we   = 1'b1;
          mem_addr = wr_cnt;
          mem_x    = in_x;
          mem_y    = in_y;
          if (wr_last) begin
            state_d = KICK;
          end
        end
      end
      KICK: begin
        if (eng_ready) begin
          eng_start = 1'b1;
          state_d   = WAIT_ACK;
        end
      end
      // Two consecutive Ready-high cycles mean the engine missed Start.
      WAIT_ACK: begin
        if (!eng_ready) begin
          state_d = WAIT_DONE;
        end else if (ack_seen_q) begin
          state_d = KICK;
        end else begin
          ack_seen_d = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (eng_ready) begin
          b0_d    = eng_b0;
          b1_d    = eng_b1;
          err_d   = eng_err;
          state_d = HOLD;
        end else if (wdog_last) begin
          timeout_d = 1'b1;
          state_d   = FILL;
        end
      end
      HOLD: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = FILL;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= FILL;
      ack_seen_q <= 1'b0;
      b0_q       <= '0;
      b1_q       <= '0;
      err_q      <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ack_seen_q <= ack_seen_d;
      b0_q       <= b0_d;
      b1_q       <= b1_d;
      err_q      <= err_d;
      timeout_q  <= timeout_d;
    end
  end

  assign res_b0  = b0_q;
  assign res_b1  = b1_q;
  assign res_err = err_q;
  assign timeout = timeout_q;
  assign busy    = (state_q != FILL);

endmodule

// File: tb/tb_regression_sample_loader.sv
// Randomized self-checking bench for regression_sample_loader: a behavioural
// model checks every output each cycle, plus directed literal expectations.
module tb_regression_sample_loader;

  localparam int DW   = 20;
  localparam int AW   = 8;
  localparam int NS   = 150;
  localparam int TO   = 4096;
  localparam int S_NS = 4;
  localparam int S_TO = 64;

  localparam int P_FILL = 0;
  localparam int P_KICK = 1;
  localparam int P_ACK  = 2;
  localparam int P_DONE = 3;
  localparam int P_HOLD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b0;
  logic          inValid = 1'b0;
  logic          inReady;
  logic [DW-1:0] inX = '0;
  logic [DW-1:0] inY = '0;
  logic          memWe;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memX, memY;
  logic          engStart;
  logic          engReady = 1'b1;
  logic [DW-1:0] engB0 = '0;
  logic [DW-1:0] engB1 = '0;
  logic [DW-1:0] engErr = '0;
  logic          resValid;
  logic          resReady = 1'b0;
  logic [DW-1:0] resB0, resB1, resErr;
  logic          timeoutO;
  logic          busy;

  logic          sRst = 1'b0;
  logic          sInValid = 1'b0;
  logic          sInReady;
  logic [DW-1:0] sInX = '0;
  logic [DW-1:0] sInY = '0;
  logic          sMemWe;
  logic [AW-1:0] sMemAddr;
  logic [DW-1:0] sMemX, sMemY;
  logic          sEngStart;
  logic          sEngReady = 1'b1;
  logic [DW-1:0] sEngB0 = 20'h12345;
  logic [DW-1:0] sEngB1 = 20'h0abcd;
  logic [DW-1:0] sEngErr = 20'h00777;
  logic          sResValid;
  logic          sResReady = 1'b0;
  logic [DW-1:0] sResB0, sResB1, sResErr;
  logic          sTimeout;
  logic          sBusy;

  regression_sample_loader #(
    .DATA_W(DW), .ADDR_W(AW), .N_SAMPLES(NS), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(inValid), .in_ready(inReady), .in_x(inX), .in_y(inY),
    .mem_we(memWe), .mem_addr(memAddr), .mem_x(memX), .mem_y(memY),
    .eng_start(engStart), .eng_ready(engReady),
    .eng_b0(engB0), .eng_b1(engB1), .eng_err(engErr),
    .res_valid(resValid), .res_ready(resReady),
    .res_b0(resB0), .res_b1(resB1), .res_err(resErr),
    .timeout(timeoutO), .busy(busy)
  );

  regression_sample_loader #(
    .DATA_W(DW), .ADDR_W(AW), .N_SAMPLES(S_NS), .TIMEOUT(S_TO)
  ) dutSmall (
    .clk(clk), .rst(sRst),
    .in_valid(sInValid), .in_ready(sInReady), .in_x(sInX), .in_y(sInY),
    .mem_we(sMemWe), .mem_addr(sMemAddr), .mem_x(sMemX), .mem_y(sMemY),
    .eng_start(sEngStart), .eng_ready(sEngReady),
    .eng_b0(sEngB0), .eng_b1(sEngB1), .eng_err(sEngErr),
    .res_valid(sResValid), .res_ready(sResReady),
    .res_b0(sResB0), .res_b1(sResB1), .res_err(sResErr),
    .timeout(sTimeout), .busy(sBusy)
  );

  int testsRun = 0;
  int testsFailed = 0;

  // Stimulus state: sample feed, engine behaviour and result consumer.
  bit rstReq = 1'b1;
  int feedMode = 0;
  int seqIdx = 0;
  int engDelay = 10;
  bit engBusy = 1'b0;
  bit engHold = 1'b0;
  int engLeft = 0;
  bit engLoseNext = 1'b0;
  bit extHold = 1'b0;
  bit fixedResult = 1'b0;
  bit resManual = 1'b0;
  bit resForce = 1'b0;

  // Observations gathered each cycle.
  bit lastStart = 1'b0;
  bit lastAccept = 1'b0;
  bit prevResValid = 1'b0;
  int cycleNo = 0;
  int startCount = 0;
  int beatCount = 0;
  int lastStartCycle = 0;
  int lastBeatCycle = 0;
  int resRiseCycle = 0;
  int bad = 0;
  logic [DW-1:0] memImgX [0:(1<<AW)-1];
  logic [DW-1:0] memImgY [0:(1<<AW)-1];

  // Reference model state.
  bit checkEn = 1'b0;
  int mPhase = P_FILL;
  int mCount = 0;
  int mAck = 0;
  int mWdog = 0;
  logic [DW-1:0] mB0 = '0;
  logic [DW-1:0] mB1 = '0;
  logic [DW-1:0] mErr = '0;
  bit mTimeout = 1'b0;
  bit eFill, eWe;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus();
    rst = !rstReq;
    if (lastAccept) seqIdx++;
    case (feedMode)
      1: begin
        inValid = 1'b1;
        inX = DW'(seqIdx);
        inY = DW'(2 * seqIdx + 3);
      end
      2: begin
        inValid = ($urandom_range(0, 99) < 70);
        inX = DW'($urandom);
        inY = DW'($urandom);
      end
      default: begin
        inValid = 1'b0;
        inX = '0;
        inY = '0;
      end
    endcase
    if (engBusy) begin
      engLeft--;
      if (engLeft <= 0 && !engHold) engBusy = 1'b0;
    end else if (lastStart) begin
      if (engLoseNext) engLoseNext = 1'b0;
      else begin
        engBusy = 1'b1;
        engLeft = engDelay;
      end
    end
    engReady = !engBusy && !extHold;
    if (fixedResult && engReady) begin
      engB0 = DW'(3);
      engB1 = DW'(2);
      engErr = '0;
    end else begin
      engB0 = DW'($urandom);
      engB1 = DW'($urandom);
      engErr = DW'($urandom);
    end
    resReady = resManual ? resForce : ($urandom_range(0, 99) < 30);
  endtask

  task automatic tick();
    @(negedge clk);
    applyStimulus();
    #1;
    lastStart = engStart;
    lastAccept = inValid && inReady;
    if (engStart) begin
      startCount++;
      lastStartCycle = cycleNo;
    end
    if (lastAccept) begin
      beatCount++;
      lastBeatCycle = cycleNo;
    end
    if (memWe) begin
      memImgX[memAddr] = memX;
      memImgY[memAddr] = memY;
    end
    if (resValid && !prevResValid) resRiseCycle = cycleNo;
    prevResValid = resValid;
    cycleNo++;
  endtask

  task automatic waitFillDone(input int limit);
    int n = 0;
    do begin
      tick();
      n++;
    end while (inReady && n < limit);
    checkOutput("fill_done_within_bound", 32'(inReady), 32'd0);
  endtask

  task automatic waitRes(input int limit);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!resValid && n < limit);
    checkOutput("res_valid_within_bound", 32'(resValid), 32'd1);
  endtask

  task automatic waitIdle(input int limit);
    int n = 0;
    do begin
      tick();
      n++;
    end while (busy && n < limit);
    checkOutput("idle_within_bound", 32'(busy), 32'd0);
  endtask

  // Per-cycle comparison of every main-DUT output against the model.
  always @(negedge clk) begin
    #2;
    if (checkEn) begin
      eFill = (mPhase == P_FILL);
      eWe = eFill && inValid;
      checkOutput("in_ready", 32'(inReady), 32'(eFill));
      checkOutput("mem_we", 32'(memWe), 32'(eWe));
      checkOutput("mem_addr", 32'(memAddr), eWe ? 32'(mCount) : 32'd0);
      checkOutput("mem_x", 32'(memX), eWe ? 32'(inX) : 32'd0);
      checkOutput("mem_y", 32'(memY), eWe ? 32'(inY) : 32'd0);
      checkOutput("eng_start", 32'(engStart), 32'(mPhase == P_KICK && engReady));
      checkOutput("res_valid", 32'(resValid), 32'(mPhase == P_HOLD));
      checkOutput("res_b0", 32'(resB0), 32'(mB0));
      checkOutput("res_b1", 32'(resB1), 32'(mB1));
      checkOutput("res_err", 32'(resErr), 32'(mErr));
      checkOutput("timeout", 32'(timeoutO), 32'(mTimeout));
      checkOutput("busy", 32'(busy), 32'(!eFill));
    end
    if (!rst) begin
      mPhase = P_FILL;
      mCount = 0;
      mAck = 0;
      mWdog = 0;
      mB0 = '0;
      mB1 = '0;
      mErr = '0;
      mTimeout = 1'b0;
      checkEn = 1'b1;
    end else if (checkEn) begin
      case (mPhase)
        P_FILL: if (inValid) begin
          if (mCount == NS - 1) begin
            mCount = 0;
            mPhase = P_KICK;
          end else mCount++;
        end
        P_KICK: if (engReady) begin
          mPhase = P_ACK;
          mAck = 0;
        end
        P_ACK: begin
          if (!engReady) begin
            mPhase = P_DONE;
            mWdog = 0;
          end else if (mAck == 1) mPhase = P_KICK;
          else mAck = 1;
        end
        P_DONE: begin
          if (engReady) begin
            mB0 = engB0;
            mB1 = engB1;
            mErr = engErr;
            mPhase = P_HOLD;
          end else if (mWdog == TO - 1) begin
            mTimeout = 1'b1;
            mPhase = P_FILL;
          end else mWdog++;
        end
        default: if (resReady) mPhase = P_FILL;
      endcase
    end
  end

  initial begin
    int n;
    for (int i = 0; i < (1 << AW); i++) begin
      memImgX[i] = '1;
      memImgY[i] = '1;
    end

    rstReq = 1'b1;
    tick();
    tick();
    rstReq = 1'b0;
    tick();
    checkOutput("reset_in_ready", 32'(inReady), 32'd1);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_res_valid", 32'(resValid), 32'd0);
    checkOutput("reset_timeout", 32'(timeoutO), 32'd0);

    // 150 samples x=i, y=2i+3; engine drops Ready then re-raises 300 cycles later.
    feedMode = 1; seqIdx = 0; engDelay = 300; fixedResult = 1'b1;
    resManual = 1'b1; resForce = 1'b0; startCount = 0; beatCount = 0;
    waitFillDone(400);
    feedMode = 0;
    checkOutput("plan_beat_count", 32'(beatCount), 32'd150);
    checkOutput("plan_start_now", 32'(engStart), 32'd1);
    checkOutput("plan_start_latency", 32'(lastStartCycle - lastBeatCycle), 32'd1);
    checkOutput("plan_mem_x0", 32'(memImgX[0]), 32'd0);
    checkOutput("plan_mem_y0", 32'(memImgY[0]), 32'd3);
    checkOutput("plan_mem_x149", 32'(memImgX[149]), 32'd149);
    checkOutput("plan_mem_y149", 32'(memImgY[149]), 32'd301);
    bad = 0;
    for (int i = 0; i < NS; i++)
      if (memImgX[i] !== DW'(i) || memImgY[i] !== DW'(2 * i + 3)) bad++;
    checkOutput("plan_mem_all", 32'(bad), 32'd0);
    checkOutput("plan_no_wrap_write", 32'(memImgX[150]), 32'hfffff);
    waitRes(600);
    checkOutput("plan_res_latency", 32'(resRiseCycle - lastStartCycle), 32'd302);
    checkOutput("plan_res_b0", 32'(resB0), 32'd3);
    checkOutput("plan_res_b1", 32'(resB1), 32'd2);
    checkOutput("plan_res_err", 32'(resErr), 32'd0);
    checkOutput("plan_start_count", 32'(startCount), 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("hold_res_valid", 32'(resValid), 32'd1);
      checkOutput("hold_res_b0", 32'(resB0), 32'd3);
    end
    resForce = 1'b1;
    tick();
    resForce = 1'b0;
    tick();
    checkOutput("release_busy", 32'(busy), 32'd0);
    checkOutput("release_in_ready", 32'(inReady), 32'd1);
    checkOutput("release_res_valid", 32'(resValid), 32'd0);
    fixedResult = 1'b0;

    // Randomized runs, one with the first Start deliberately lost.
    resManual = 1'b0;
    for (int r = 0; r < 4; r++) begin
      feedMode = 2;
      engDelay = $urandom_range(1, 400);
      engLoseNext = (r == 1) || ($urandom_range(0, 3) == 0);
      waitFillDone(2000);
      feedMode = 0;
      waitIdle(3000);
    end

    // Engine busy when the fill completes, released after 5 cycles.
    extHold = 1'b1; feedMode = 1; seqIdx = 0; engDelay = 20; startCount = 0;
    waitFillDone(400);
    feedMode = 0;
    checkOutput("ext_no_start_at_kick", 32'(startCount), 32'd0);
    repeat (4) tick();
    checkOutput("ext_still_no_start", 32'(startCount), 32'd0);
    checkOutput("ext_busy_in_kick", 32'(busy), 32'd1);
    extHold = 1'b0;
    tick();
    checkOutput("ext_start_pulse", 32'(engStart), 32'd1);
    tick();
    checkOutput("ext_start_single", 32'(engStart), 32'd0);
    waitIdle(500);
    checkOutput("ext_start_count", 32'(startCount), 32'd1);

    // Reset asserted for one cycle while a result is held.
    resManual = 1'b1; resForce = 1'b0; feedMode = 1; seqIdx = 0; engDelay = 10;
    waitFillDone(400);
    feedMode = 0;
    waitRes(100);
    tick();
    tick();
    rstReq = 1'b1;
    tick();
    rstReq = 1'b0;
    tick();
    checkOutput("midhold_in_ready", 32'(inReady), 32'd1);
    checkOutput("midhold_res_valid", 32'(resValid), 32'd0);
    checkOutput("midhold_res_b0", 32'(resB0), 32'd0);
    checkOutput("midhold_busy", 32'(busy), 32'd0);
    checkOutput("midhold_mem_we", 32'(memWe), 32'd0);
    resManual = 1'b0;

    // Small instance: engine never re-raises Ready, 64-cycle watchdog.
    sRst = 1'b0;
    tick();
    sRst = 1'b1; sEngReady = 1'b1; sInValid = 1'b1;
    n = 0;
    do begin
      sInX = DW'(n);
      sInY = DW'(n + 1);
      tick();
      n++;
    end while (sInReady && n < 20);
    checkOutput("small_fill_beats", 32'(n), 32'd4);
    checkOutput("small_start", 32'(sEngStart), 32'd1);
    tick();
    sEngReady = 1'b0;
    sInValid = 1'b0;
    repeat (64) tick();
    checkOutput("small_timeout_not_yet", 32'(sTimeout), 32'd0);
    checkOutput("small_busy_waiting", 32'(sBusy), 32'd1);
    tick();
    checkOutput("small_timeout_set", 32'(sTimeout), 32'd1);
    checkOutput("small_back_in_fill", 32'(sBusy), 32'd0);
    checkOutput("small_in_ready", 32'(sInReady), 32'd1);
    checkOutput("small_res_valid", 32'(sResValid), 32'd0);
    checkOutput("small_res_b0", 32'(sResB0), 32'd0);
    checkOutput("small_res_b1", 32'(sResB1), 32'd0);
    checkOutput("small_res_err", 32'(sResErr), 32'd0);
    repeat (3) tick();
    checkOutput("small_timeout_sticky", 32'(sTimeout), 32'd1);
    sRst = 1'b0;
    tick();
    sRst = 1'b1;
    tick();
    checkOutput("small_timeout_cleared", 32'(sTimeout), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
